// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared sizing constants for the register-file writeback path.
// Revision    : 1.0
// ============================================================================
package regfile_pkg;

    localparam int REGFILE_W     = 32;
    localparam int REGFILE_AW    = 5;
    localparam int REGFILE_NREG  = 2 ** REGFILE_AW;
    localparam int REGFILE_N_REQ = 3;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter with a rotating priority pointer.
// Revision    : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  i_req,
    input  logic          i_hs_en,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_grant_idx
);

    logic [IW-1:0] r_ptr;
    logic          w_found;
    int            w_j;

    // Search starts at the pointer and wraps, so the last winner has lowest priority.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_j         = 0;
        for (int k = 0; k < N; k++) begin
            w_j = int'(r_ptr) + k;
            if (w_j >= N) begin
                w_j = w_j - N;
            end
            if (!w_found && i_req[w_j]) begin
                w_found        = 1'b1;
                o_grant[w_j]   = 1'b1;
                o_grant_idx    = IW'(w_j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (i_hs_en && w_found) begin
            r_ptr <= (o_grant_idx == IW'(N - 1)) ? '0 : o_grant_idx + IW'(1);
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_scheduler
// Description : Shares the register-file write port between writeback
//               requesters and tracks pending writes for hazard detection.
// Revision    : 1.0
// ============================================================================
module regfile_wb_scheduler
    import regfile_pkg::*;
#(
    parameter int W             = REGFILE_W,
    parameter int W_reg_address = REGFILE_AW,
    parameter int N_REQ         = REGFILE_N_REQ
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_REQ-1:0]                 req_valid,
    input  logic [N_REQ*W_reg_address-1:0]   req_addr,
    input  logic [N_REQ*W-1:0]               req_data,
    output logic [N_REQ-1:0]                 req_ready,
    input  logic                             rsv_valid,
    input  logic [W_reg_address-1:0]         rsv_addr,
    input  logic [W_reg_address-1:0]         chk_a1,
    input  logic [W_reg_address-1:0]         chk_a2,
    input  logic [W_reg_address-1:0]         chk_a3,
    output logic                             hazard,
    output logic [(2**W_reg_address)-1:0]    busy,
    output logic                             WE3,
    output logic [W_reg_address-1:0]         A3,
    output logic [W-1:0]                     WD3
);

    localparam int NREG = 2 ** W_reg_address;
    localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]         w_grant;
    logic [IW-1:0]            w_gidx;
    logic                     w_hs;
    logic [W_reg_address-1:0] w_sel_addr;
    logic [W-1:0]             w_sel_data;
    logic [NREG-1:0]          w_busy_nxt;

    logic                     r_we3;
    logic [W_reg_address-1:0] r_a3;
    logic [W-1:0]             r_wd3;
    logic [NREG-1:0]          r_busy;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .i_req       (req_valid),
        .i_hs_en     (w_hs),
        .o_grant     (w_grant),
        .o_grant_idx (w_gidx)
    );

    // Every grant is a handshake: ready is only raised for a valid requester.
    assign req_ready  = w_grant;
    assign w_hs       = |w_grant;
    assign w_sel_addr = req_addr[int'(w_gidx) * W_reg_address +: W_reg_address];
    assign w_sel_data = req_data[int'(w_gidx) * W +: W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we3 <= 1'b0;
            r_a3  <= '0;
            r_wd3 <= '0;
        end else if (w_hs) begin
            r_we3 <= (w_sel_addr != '0);
            r_a3  <= w_sel_addr;
            r_wd3 <= w_sel_data;
        end else begin
            r_we3 <= 1'b0;
        end
    end

    // Clear is applied before set so a same-cycle reservation wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_we3) begin
            w_busy_nxt[r_a3] = 1'b0;
        end
        if (rsv_valid && (rsv_addr != '0)) begin
            w_busy_nxt[rsv_addr] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign hazard = r_busy[chk_a1] | r_busy[chk_a2] | r_busy[chk_a3];
    assign busy   = r_busy;
    assign WE3    = r_we3;
    assign A3     = r_a3;
    assign WD3    = r_wd3;

    a_no_double_reserve : assert property (
        @(posedge clk) disable iff (!rst)
        !(rsv_valid && (rsv_addr != '0) && r_busy[rsv_addr])
    );

endmodule : regfile_wb_scheduler
`default_nettype wire

// File: tb/tb_regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_scheduler
// Description : Directed, table-driven bench for the writeback scheduler.
// Revision    : 1.0
// ============================================================================
module tb_regfile_wb_scheduler;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam int NR = 3;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*W-1:0]   req_data;
    logic [NR-1:0]     req_ready;
    logic              rsv_valid;
    logic [AW-1:0]     rsv_addr;
    logic [AW-1:0]     chk_a1;
    logic [AW-1:0]     chk_a2;
    logic [AW-1:0]     chk_a3;
    logic              hazard;
    logic [31:0]       busy;
    logic              WE3;
    logic [AW-1:0]     A3;
    logic [W-1:0]      WD3;

    int n_checks;
    int n_fail;

    regfile_wb_scheduler #(
        .W             (W),
        .W_reg_address (AW),
        .N_REQ         (NR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .chk_a1    (chk_a1),
        .chk_a2    (chk_a2),
        .chk_a3    (chk_a3),
        .hazard    (hazard),
        .busy      (busy),
        .WE3       (WE3),
        .A3        (A3),
        .WD3       (WD3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]    valid;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        logic [W-1:0]  d0;
        logic [W-1:0]  d1;
        logic [W-1:0]  d2;
        logic [2:0]    exp_ready;
        logic          exp_we;
        logic          chk_port;
        logic [AW-1:0] exp_a3;
        logic [W-1:0]  exp_wd3;
    } vec_t;

    vec_t tv [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic [2:0] v,
                             input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                             input logic [W-1:0] d0, input logic [W-1:0] d1, input logic [W-1:0] d2);
        req_valid = v;
        req_addr  = {a2, a1, a0};
        req_data  = {d2, d1, d0};
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [2:0] v,
                                input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                                input logic [W-1:0] d0, input logic [W-1:0] d1, input logic [W-1:0] d2,
                                input logic [2:0] rdy, input logic we, input logic cp,
                                input logic [AW-1:0] ea3, input logic [W-1:0] ewd);
        vec_t t;
        t.valid = v;   t.a0 = a0; t.a1 = a1; t.a2 = a2;
        t.d0 = d0;     t.d1 = d1; t.d2 = d2;
        t.exp_ready = rdy; t.exp_we = we; t.chk_port = cp;
        t.exp_a3 = ea3;    t.exp_wd3 = ewd;
        return t;
    endfunction

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b0;
        rsv_valid = 1'b0;
        rsv_addr  = '0;
        chk_a1    = '0;
        chk_a2    = '0;
        chk_a3    = '0;

        // Round robin from ptr=0, idle hold, latency, wrap-around and x0 rows.
        tv[0]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h100, 32'h200, 32'h300, 3'b001, 1'b1, 1'b1, 5'd1, 32'h100);
        tv[1]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h100, 32'h200, 32'h300, 3'b010, 1'b1, 1'b1, 5'd2, 32'h200);
        tv[2]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h100, 32'h200, 32'h300, 3'b100, 1'b1, 1'b1, 5'd3, 32'h300);
        tv[3]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h100, 32'h200, 32'h300, 3'b001, 1'b1, 1'b1, 5'd1, 32'h100);
        tv[4]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h100, 32'h200, 32'h300, 3'b010, 1'b1, 1'b1, 5'd2, 32'h200);
        tv[5]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h100, 32'h200, 32'h300, 3'b100, 1'b1, 1'b1, 5'd3, 32'h300);
        tv[6]  = mk(3'b000, 5'd1, 5'd2, 5'd3, 32'h100, 32'h200, 32'h300, 3'b000, 1'b0, 1'b1, 5'd3, 32'h300);
        tv[7]  = mk(3'b010, 5'd0, 5'd5, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0, 3'b010, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
        tv[8]  = mk(3'b000, 5'd0, 5'd5, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0, 3'b000, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
        tv[9]  = mk(3'b011, 5'd8, 5'd6, 5'd0, 32'h88, 32'h66, 32'h0, 3'b001, 1'b1, 1'b1, 5'd8, 32'h88);
        tv[10] = mk(3'b010, 5'd8, 5'd6, 5'd0, 32'h88, 32'h66, 32'h0, 3'b010, 1'b1, 1'b1, 5'd6, 32'h66);
        tv[11] = mk(3'b100, 5'd8, 5'd6, 5'd0, 32'h88, 32'h66, 32'hABC, 3'b100, 1'b0, 1'b0, 5'd0, 32'h0);
        tv[12] = mk(3'b001, 5'd10, 5'd6, 5'd0, 32'hA0, 32'h66, 32'hABC, 3'b001, 1'b1, 1'b1, 5'd10, 32'hA0);

        // Reset held for 3 cycles with every requester valid.
        drive_req(3'b111, 5'd1, 5'd2, 5'd3, 32'h100, 32'h200, 32'h300);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            chk("reset_we3", 64'(WE3), 64'd0);
            chk("reset_busy", 64'(busy), 64'd0);
        end
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive_req(tv[i].valid, tv[i].a0, tv[i].a1, tv[i].a2, tv[i].d0, tv[i].d1, tv[i].d2);
            #1;
            chk($sformatf("vec%0d_ready", i), 64'(req_ready), 64'(tv[i].exp_ready));
            next_cycle();
            chk($sformatf("vec%0d_we3", i), 64'(WE3), 64'(tv[i].exp_we));
            if (tv[i].chk_port) begin
                chk($sformatf("vec%0d_a3", i), 64'(A3), 64'(tv[i].exp_a3));
                chk($sformatf("vec%0d_wd3", i), 64'(WD3), 64'(tv[i].exp_wd3));
            end
            chk($sformatf("vec%0d_busy", i), 64'(busy), 64'd0);
        end

        // Scoreboard: reserve r7 at T, writeback handshake at T+4.
        drive_req(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        chk_a1    = 5'd7;
        rsv_valid = 1'b1;
        rsv_addr  = 5'd7;
        #1;
        chk("sb_hazard_T", 64'(hazard), 64'd0);
        next_cycle();
        rsv_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("sb_hazard_T%0d", i), 64'(hazard), 64'd1);
            chk($sformatf("sb_busy7_T%0d", i), 64'(busy[7]), 64'd1);
            if (i < 3) next_cycle();
        end
        next_cycle();
        drive_req(3'b001, 5'd7, 5'd0, 5'd0, 32'h77, 32'h0, 32'h0);
        #1;
        chk("sb_ready_T4", 64'(req_ready), 64'b001);
        next_cycle();
        drive_req(3'b000, 5'd7, 5'd0, 5'd0, 32'h77, 32'h0, 32'h0);
        chk("sb_we3_T5", 64'(WE3), 64'd1);
        chk("sb_a3_T5", 64'(A3), 64'd7);
        chk("sb_busy7_T5", 64'(busy[7]), 64'd1);
        chk("sb_hazard_T5", 64'(hazard), 64'd1);
        next_cycle();
        chk("sb_busy7_T6", 64'(busy[7]), 64'd0);
        chk("sb_hazard_T6", 64'(hazard), 64'd0);
        chk("sb_we3_T6", 64'(WE3), 64'd0);

        // Untracked writeback to r9 while r9 is reserved in the write cycle: set wins.
        chk_a1 = 5'd0;
        chk_a3 = 5'd9;
        drive_req(3'b010, 5'd0, 5'd9, 5'd0, 32'h0, 32'h99, 32'h0);
        #1;
        chk("sw_ready", 64'(req_ready), 64'b010);
        next_cycle();
        drive_req(3'b000, 5'd0, 5'd9, 5'd0, 32'h0, 32'h99, 32'h0);
        chk("sw_we3", 64'(WE3), 64'd1);
        chk("sw_a3", 64'(A3), 64'd9);
        chk("sw_busy9_pre", 64'(busy[9]), 64'd0);
        rsv_valid = 1'b1;
        rsv_addr  = 5'd9;
        #1;
        chk("sw_hazard_pre", 64'(hazard), 64'd0);
        next_cycle();
        chk("sw_busy9_post", 64'(busy[9]), 64'd1);
        chk("sw_hazard_post", 64'(hazard), 64'd1);

        // Reservation of x0 is ignored.
        rsv_addr = 5'd0;
        next_cycle();
        rsv_valid = 1'b0;
        chk("x0_rsv_busy", 64'(busy), 64'h200);

        // Mid-operation reset: handshake, then asynchronous reset while WE3 is high.
        drive_req(3'b001, 5'd4, 5'd9, 5'd0, 32'h44, 32'h99, 32'h0);
        #1;
        chk("mr_ready", 64'(req_ready), 64'b001);
        next_cycle();
        drive_req(3'b000, 5'd4, 5'd9, 5'd0, 32'h44, 32'h99, 32'h0);
        chk("mr_we3_pre", 64'(WE3), 64'd1);
        chk("mr_a3_pre", 64'(A3), 64'd4);
        #2;
        rst = 1'b0;
        #1;
        chk("mr_we3_async", 64'(WE3), 64'd0);
        chk("mr_a3_async", 64'(A3), 64'd0);
        chk("mr_wd3_async", 64'(WD3), 64'd0);
        chk("mr_busy_async", 64'(busy), 64'd0);
        next_cycle();
        chk("mr_we3_held", 64'(WE3), 64'd0);
        rst = 1'b1;
        drive_req(3'b111, 5'd1, 5'd2, 5'd3, 32'h100, 32'h200, 32'h300);
        #1;
        chk("mr_ptr_ready", 64'(req_ready), 64'b001);
        next_cycle();
        chk("mr_we3_post", 64'(WE3), 64'd1);
        chk("mr_a3_post", 64'(A3), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_regfile_wb_scheduler
`default_nettype wire
